// File: rtl/wam_pkg.sv
// Shared phase encodings and hardness helpers for the whac-a-mole round controller.
package wam_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_READY = 3'd1,
    PH_PLAY  = 3'd2,
    PH_PAUSE = 3'd3,
    PH_OVER  = 3'd4
  } phase_t;

  localparam logic [3:0] MAX_HRDN = 4'd9;

  // Mole lifetime shrinks with hardness but never below 3.
  function automatic logic [3:0] hrdn_age(input logic [3:0] h);
    return (h >= MAX_HRDN) ? 4'd3 : (4'd12 - h);
  endfunction

  function automatic logic [7:0] hrdn_rto(input logic [3:0] h);
    logic [3:0] hp1;
    hp1 = h + 4'd1;
    return {hp1, 4'b0000};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/wam_edge.sv
// Rising-edge detector: the history bit is registered, the pulse is combinational
// so the controller reacts on the very next clock edge.
module wam_edge (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/wam_ctl.sv
// Whac-a-mole round sequencer: READY countdown, PLAY, PAUSE, OVER, hardness tracking.
// Optional build macro WAM_CTL_BONUS_EN adds +5 s per hardness increment in PLAY.
module wam_ctl
  import wam_pkg::*;
#(
  parameter int TICKS_PER_SEC = 8,
  parameter int ROUND_SEC     = 60,
  parameter int READY_SEC     = 3,
  parameter int LVL_STEP      = 10
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pse,
  input  logic [7:0] hit,
  input  logic [3:0] lvl0,
  output logic       run,
  output logic       gen_clr,
  output logic [3:0] hrdn,
  output logic [3:0] age,
  output logic [7:0] rto,
  output logic [6:0] sec_left,
  output logic [2:0] phase,
  output logic       over
);

  localparam int              SUB_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [8:0]      STEP     = 9'(LVL_STEP);
  localparam logic [6:0]      ROUND_V  = 7'(ROUND_SEC);
  localparam logic [6:0]      READY_V  = 7'(READY_SEC);

  phase_t           ph_q, ph_nxt;
  logic [SUB_W-1:0] sub_q, sub_nxt, sub_inc;
  logic [8:0]       acc_q, acc_nxt, acc_sum, acc_lvl, acc_play;
  logic [6:0]       sec_nxt, sec_play;
  logic [7:0]       sec_base;
  logic [3:0]       hrdn_nxt, hrdn_play, hit_cnt, lvl_clamp;
  logic             run_nxt, gen_clr_nxt, over_nxt;
  logic             start_rise, pse_rise;
  logic             sub_wrap, ready_sec, play_tick, play_sec, lvl_up, launch;

  wam_edge u_start_edge (.clk(clk), .clr_n(clr_n), .d(start), .rise(start_rise));
  wam_edge u_pse_edge   (.clk(clk), .clr_n(clr_n), .d(pse),   .rise(pse_rise));

  assign lvl_clamp = (lvl0 > MAX_HRDN) ? MAX_HRDN : lvl0;
  assign sub_wrap  = (sub_q == SUB_LAST);
  assign sub_inc   = sub_wrap ? '0 : (sub_q + SUB_W'(1));
  assign ready_sec = tick & sub_wrap;
  // A pause request swallows a coincident tick entirely, sub-tick included.
  assign play_tick = tick & ~pse_rise;
  assign play_sec  = play_tick & sub_wrap;
  assign launch    = start_rise & ((ph_q == PH_IDLE) | (ph_q == PH_OVER));

  // Hit accumulation: one level per cycle at most, remainder carries over.
  assign hit_cnt   = popcount8(hit);
  assign acc_sum   = acc_q + {5'd0, hit_cnt};
  assign lvl_up    = (hrdn_q_sat() == 1'b0) & (acc_sum >= STEP);
  assign hrdn_play = hrdn + {3'd0, lvl_up};
  assign acc_lvl   = lvl_up ? (acc_sum - STEP) : acc_sum;
  assign acc_play  = ((hrdn_play == MAX_HRDN) && (acc_lvl > (STEP - 9'd1))) ? (STEP - 9'd1) : acc_lvl;

  function automatic logic hrdn_q_sat();
    return (hrdn == MAX_HRDN);
  endfunction

  assign sec_base = {1'b0, sec_left} - {7'd0, play_sec};
`ifdef WAM_CTL_BONUS_EN
  logic [7:0] sec_bon;
  assign sec_bon  = lvl_up ? (sec_base + 8'd5) : sec_base;
  assign sec_play = (sec_bon > 8'd99) ? 7'd99 : sec_bon[6:0];
`else
  assign sec_play = sec_base[6:0];
`endif

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ph_q     <= PH_IDLE;
      sub_q    <= '0;
      acc_q    <= '0;
      sec_left <= '0;
      hrdn     <= '0;
      age      <= hrdn_age(4'd0);
      rto      <= hrdn_rto(4'd0);
      run      <= 1'b0;
      gen_clr  <= 1'b0;
      over     <= 1'b0;
    end else begin
      ph_q     <= ph_nxt;
      sub_q    <= sub_nxt;
      acc_q    <= acc_nxt;
      sec_left <= sec_nxt;
      hrdn     <= hrdn_nxt;
      age      <= hrdn_age(hrdn_nxt);
      rto      <= hrdn_rto(hrdn_nxt);
      run      <= run_nxt;
      gen_clr  <= gen_clr_nxt;
      over     <= over_nxt;
    end
  end

  // Next-phase decode
  always_comb begin
    ph_nxt = ph_q;
    case (ph_q)
      PH_IDLE, PH_OVER: if (start_rise) ph_nxt = PH_READY;
      PH_READY:         if (ready_sec && sec_left == 7'd1) ph_nxt = PH_PLAY;
      PH_PLAY: begin
        if (pse_rise)              ph_nxt = PH_PAUSE;
        else if (sec_play == 7'd0) ph_nxt = PH_OVER;
      end
      PH_PAUSE:         if (pse_rise) ph_nxt = PH_PLAY;
      default:          ph_nxt = PH_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sub_nxt     = sub_q;
    acc_nxt     = acc_q;
    sec_nxt     = sec_left;
    hrdn_nxt    = hrdn;
    run_nxt     = (ph_nxt == PH_PLAY);
    over_nxt    = (ph_nxt == PH_OVER);
    gen_clr_nxt = launch;
    case (ph_q)
      PH_IDLE, PH_OVER: begin
        if (launch) begin
          sub_nxt  = '0;
          acc_nxt  = '0;
          sec_nxt  = READY_V;
          hrdn_nxt = lvl_clamp;
        end
      end
      PH_READY: begin
        if (tick) sub_nxt = sub_inc;
        if (ready_sec) sec_nxt = (sec_left == 7'd1) ? ROUND_V : (sec_left - 7'd1);
      end
      PH_PLAY: begin
        if (play_tick) sub_nxt = sub_inc;
        acc_nxt  = acc_play;
        hrdn_nxt = hrdn_play;
        sec_nxt  = sec_play;
      end
      default: ;
    endcase
  end

  assign phase = ph_q;

endmodule

// File: tb/tb_wam_ctl.sv
// Bench for wam_ctl: table-driven start sequence, hand-written corner sequences,
// and a behavioural model feeding a scoreboard queue checked every cycle.
module tb_wam_ctl;

  localparam int TPS       = 8;
  localparam int ROUND_SEC = 60;
  localparam int READY_SEC = 3;
  localparam int LVL       = 10;
`ifdef WAM_CTL_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, pse = 1'b0;
  logic [7:0] hit = 8'd0;
  logic [3:0] lvl0 = 4'd0;
  logic       run, gen_clr, over;
  logic [3:0] hrdn, age;
  logic [7:0] rto;
  logic [6:0] sec_left;
  logic [2:0] phase;

  wam_ctl #(.TICKS_PER_SEC(TPS), .ROUND_SEC(ROUND_SEC), .READY_SEC(READY_SEC), .LVL_STEP(LVL)) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick), .start(start), .pse(pse), .hit(hit), .lvl0(lvl0),
    .run(run), .gen_clr(gen_clr), .hrdn(hrdn), .age(age), .rto(rto),
    .sec_left(sec_left), .phase(phase), .over(over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] sec;
    logic [3:0] hr;
    logic [3:0] ag;
    logic [7:0] rt;
    logic       run;
    logic       over;
    logic       gc;
  } obs_t;

  typedef struct {
    bit         s, p, t;
    logic [7:0] hv;
    logic [2:0] ph;
    logic [6:0] sec;
    logic [3:0] hr, ag;
    logic [7:0] rt;
    bit         run, gc;
  } vec_t;

  obs_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  int m_ph, m_sec, m_h, m_acc, m_sub;
  bit m_ps, m_pp, m_gc;

  function automatic obs_t observe();
    obs_t o;
    o = '{ph: phase, sec: sec_left, hr: hrdn, ag: age, rt: rto, run: run, over: over, gc: gen_clr};
    return o;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_sec = 0; m_h = 0; m_acc = 0; m_sub = 0;
    m_ps = 1'b0; m_pp = 1'b0; m_gc = 1'b0;
    sbq.delete();
  endfunction

  function automatic void model(bit s, bit p, bit t, logic [7:0] hv, int l0);
    bit se, pe, dec, up;
    obs_t e;
    se = s && !m_ps;
    pe = p && !m_pp;
    m_ps = s; m_pp = p; m_gc = 1'b0;
    case (m_ph)
      0, 4: if (se) begin
        m_ph = 1; m_gc = 1'b1; m_sec = READY_SEC; m_h = (l0 > 9) ? 9 : l0; m_acc = 0; m_sub = 0;
      end
      1: if (t) begin
        if (m_sub == TPS - 1) begin
          m_sub = 0;
          if (m_sec == 1) begin m_ph = 2; m_sec = ROUND_SEC; end
          else m_sec = m_sec - 1;
        end else m_sub = m_sub + 1;
      end
      2: begin
        m_acc = m_acc + $countones(hv);
        up = 1'b0;
        if (m_h < 9 && m_acc >= LVL) begin m_acc = m_acc - LVL; m_h = m_h + 1; up = 1'b1; end
        if (m_h == 9 && m_acc > LVL - 1) m_acc = LVL - 1;
        dec = 1'b0;
        if (!pe && t) begin
          if (m_sub == TPS - 1) begin m_sub = 0; dec = 1'b1; end
          else m_sub = m_sub + 1;
        end
        m_sec = m_sec - int'(dec);
        if (BONUS && up) m_sec = (m_sec + 5 > 99) ? 99 : m_sec + 5;
        if (pe) m_ph = 3;
        else if (m_sec == 0) m_ph = 4;
      end
      3: if (pe) m_ph = 2;
      default: ;
    endcase
    e.ph = 3'(m_ph); e.sec = 7'(m_sec); e.hr = 4'(m_h);
    e.ag = (m_h >= 9) ? 4'd3 : 4'(12 - m_h);
    e.rt = 8'(16 * (m_h + 1));
    e.run = (m_ph == 2); e.over = (m_ph == 4); e.gc = m_gc;
    sbq.push_back(e);
  endfunction

  task automatic sb_check(input string nm);
    obs_t e, a;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", nm, observe());
    end else begin
      e = sbq.pop_front();
      a = observe();
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got ph=%0d sec=%0d hr=%0d age=%0d rto=%0d run=%0b over=%0b gc=%0b expected ph=%0d sec=%0d hr=%0d age=%0d rto=%0d run=%0b over=%0b gc=%0b",
                 nm, a.ph, a.sec, a.hr, a.ag, a.rt, a.run, a.over, a.gc,
                 e.ph, e.sec, e.hr, e.ag, e.rt, e.run, e.over, e.gc);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic cyc(input bit s, input bit p, input bit t, input logic [7:0] hv, input string nm);
    start = s; pse = p; tick = t; hit = hv;
    model(s, p, t, hv, int'(lvl0));
    @(posedge clk);
    #1;
    sb_check(nm);
  endtask

  task automatic ticks(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00, nm);
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_phase"}, 32'(phase), 0);
    chk({nm, "_run_over_gc"}, {29'd0, run, over, gen_clr}, 0);
    chk({nm, "_sec_hrdn"}, {21'd0, sec_left, hrdn}, 0);
    chk({nm, "_age_rto"}, {20'd0, age, rto}, {20'd0, 4'd12, 8'd16});
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{s:1, p:0, t:0, hv:8'h00, ph:1, sec:3, hr:2, ag:10, rt:48, run:0, gc:1};
    tbl[1] = '{s:1, p:0, t:0, hv:8'h00, ph:1, sec:3, hr:2, ag:10, rt:48, run:0, gc:0};
    tbl[2] = '{s:0, p:0, t:1, hv:8'h00, ph:1, sec:3, hr:2, ag:10, rt:48, run:0, gc:0};
    tbl[3] = '{s:1, p:0, t:0, hv:8'h00, ph:1, sec:3, hr:2, ag:10, rt:48, run:0, gc:0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_check("reset");
    clr_n = 1'b1;
    lvl0 = 4'd2;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "idle");

    // Round 1: start sequence from the table
    for (int i = 0; i < 4; i++) begin
      start = tbl[i].s; pse = tbl[i].p; tick = tbl[i].t; hit = tbl[i].hv;
      model(tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].hv, int'(lvl0));
      @(posedge clk);
      #1;
      sb_check($sformatf("tbl%0d_sb", i));
      chk($sformatf("tbl%0d_out", i),
          {1'b0, phase, sec_left, hrdn, age, rto, run, gen_clr},
          {1'b0, tbl[i].ph, tbl[i].sec, tbl[i].hr, tbl[i].ag, tbl[i].rt, tbl[i].run, tbl[i].gc});
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "rel");
    ticks(22, "ready_cnt");
    chk("ready_before_play", {25'd0, phase, sec_left}, {25'd0, 3'd1, 7'd1});
    ticks(1, "ready_last");
    chk("play_entry", {24'd0, run, phase, sec_left}, {24'd0, 1'b1, 3'd2, 7'd60});

    // Hardness from hits: 16 hits then 4 singles
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, "hitff1");
    chk("hrdn_after_8", 32'(hrdn), 2);
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, "hitff2");
    chk("hrdn_after_16", 32'(hrdn), 3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h01, "hit1");
    chk("hrdn_after_19", 32'(hrdn), 3);
    cyc(1'b0, 1'b0, 1'b0, 8'h10, "hit20");
    chk("hrdn_after_20", {20'd0, hrdn, rto}, {20'd0, 4'd4, 8'd80});
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "quiet");

    ticks(479, "play_run");
    chk("play_sec1", {25'd0, phase, sec_left}, {25'd0, 3'd2, 7'd1});
    ticks(1, "play_last");
    chk("over_state", {22'd0, over, run, phase, sec_left}, {22'd0, 1'b1, 1'b0, 3'd4, 7'd0});
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 8'h0F, "over_hold");
    chk("over_hold", {21'd0, phase, sec_left, hrdn}, {21'd0, 3'd4, 7'd0, 4'd4});

    // Round 2: clamp, pause/tick race, ignored starts, mid-round reset
    lvl0 = 4'd12;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "r2_start");
    chk("r2_clamp", {17'd0, gen_clr, hrdn, age, rto}, {17'd0, 1'b1, 4'd9, 4'd3, 8'd160});
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "r2_rel");
    ticks(24, "r2_ready");
    ticks(7, "r2_sub");
    cyc(1'b0, 1'b1, 1'b1, 8'h00, "pse_tick");
    chk("pause_entry", {24'd0, run, phase, sec_left}, {24'd0, 1'b0, 3'd3, 7'd60});
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "start_in_pause");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "rel_pause");
    chk("start_ignored_pause", {28'd0, gen_clr, phase}, {28'd0, 1'b0, 3'd3});
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF, "pause_ticks");
    chk("pause_hold", 32'(sec_left), 60);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "resume");
    chk("resume_play", {28'd0, run, phase}, {28'd0, 1'b1, 3'd2});
    cyc(1'b0, 1'b0, 1'b1, 8'h00, "resume_tick");
    chk("sub_resumed", 32'(sec_left), 59);
    cyc(1'b1, 1'b0, 1'b0, 8'hFF, "start_in_play");
    chk("start_ignored_play", {21'd0, gen_clr, phase, sec_left}, {21'd0, 1'b0, 3'd2, 7'd59});
    cyc(1'b0, 1'b0, 1'b0, 8'hFF, "hrdn_sat");
    chk("hrdn_sat", 32'(hrdn), 9);
    start = 1'b0; pse = 1'b0; tick = 1'b0; hit = 8'h00;
    #3 clr_n = 1'b0;
    #1;
    reset_check("midreset");
    model_reset();
    @(posedge clk);
    #1;
    chk("midreset_no_gc", {28'd0, gen_clr, phase}, 0);
    clr_n = 1'b1;

    // Round 3: level-up on the final tick
    lvl0 = 4'd0;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "r3_start");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "r3_rel");
    ticks(24, "r3_ready");
    cyc(1'b0, 1'b0, 1'b0, 8'h03, "r3_pre_hits");
    ticks(479, "r3_run");
    chk("r3_sec1", 32'(sec_left), 1);
    cyc(1'b0, 1'b0, 1'b1, 8'hFF, "r3_final");
    chk("final_phase", 32'(phase), BONUS ? 32'd2 : 32'd4);
    chk("final_sec", 32'(sec_left), BONUS ? 32'd5 : 32'd0);
    chk("final_hrdn", 32'(hrdn), 1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "r3_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
